// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 write controller.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWRUP,
    INIT,
    IDLE,
    SETUP,
    ENH,
    HOLD,
    EXEC
  } lcd_state_e;

  localparam int unsigned INIT_LEN = 5;
  localparam logic [7:0] INIT_ROM [INIT_LEN] = '{8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

  localparam logic [7:0] LCD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_HOME  = 8'h02;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_req_t;

  // Clear (0x01) and home (0x02/0x03) need the long execute time.
  function automatic logic is_long_cmd(input lcd_req_t req);
    return !req.rs && ((req.data == LCD_CLEAR) || (req.data[7:1] == LCD_HOME[7:1]));
  endfunction

endpackage

// File: rtl/lcd_req_fifo.sv
// Synchronous request FIFO; a pop frees an entry for a push in the same cycle.
module lcd_req_fifo
  import lcd_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  lcd_req_t                 din,
  input  logic                     pop,
  output lcd_req_t                 head_c,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned COUNT_W = PTR_W + 1;

  lcd_req_t             mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [COUNT_W-1:0]   count_next;
  logic                 do_push;
  logic                 do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head_c  = mem[rd_ptr];

  always_comb begin
    count_next = count + COUNT_W'(do_push) - COUNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
      full  <= (count_next == COUNT_W'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  // Storage needs no reset; pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/lcd_ctrl.sv
// Queues LSU writes and replays them to an HD44780 LCD after a power-on
// init sequence, generating setup/enable/hold/execute timing.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned T_POWERUP   = 750000,
  parameter int unsigned T_SETUP     = 4,
  parameter int unsigned T_EN        = 12,
  parameter int unsigned T_HOLD      = 2,
  parameter int unsigned T_EXEC      = 1850,
  parameter int unsigned T_EXEC_LONG = 76000,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned CNT_W       = 20
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  logic [9:0]  req_data_i,
  output logic        req_ready_o,
  output logic [7:0]  lcd_data_o,
  output logic        lcd_rs_o,
  output logic        lcd_rw_o,
  output logic        lcd_en_o,
  output logic        lcd_on_o,
  output logic        busy_o,
  output logic [31:0] status_o
);

  localparam int unsigned COUNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned IDX_W   = $clog2(INIT_LEN);

  lcd_state_e          state;
  lcd_state_e          state_next;
  logic [CNT_W-1:0]    timer;
  logic [CNT_W-1:0]    timer_next;
  logic [CNT_W-1:0]    exec_last;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    idx_next;
  logic                init_done;
  logic                init_done_next;
  lcd_req_t            out_req;
  lcd_req_t            out_req_next;
  logic                en_next;
  logic                overflow;

  lcd_req_t            req_in;
  lcd_req_t            head_c;
  logic                push;
  logic                pop;
  logic                full;
  logic                empty;
  logic [COUNT_W-1:0]  fifo_count;
  logic                unused_rsvd;

  assign req_in      = {req_data_i[9], req_data_i[7:0]};
  assign unused_rsvd = req_data_i[8];

  assign req_ready_o = (!full || pop) && !rst_i;
  assign push        = req_valid_i && req_ready_o;

  lcd_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk_i),
    .rst    (rst_i),
    .push   (push),
    .din    (req_in),
    .pop    (pop),
    .head_c (head_c),
    .full   (full),
    .empty  (empty),
    .count  (fifo_count)
  );

  assign exec_last = is_long_cmd(out_req) ? CNT_W'(T_EXEC_LONG - 1) : CNT_W'(T_EXEC - 1);

  // Next-state, timer and output-latch logic; each phase lasts exactly its parameter.
  always_comb begin
    state_next     = state;
    timer_next     = timer + CNT_W'(1);
    idx_next       = idx;
    init_done_next = init_done;
    out_req_next   = out_req;
    pop            = 1'b0;
    unique case (state)
      PWRUP: if (timer == CNT_W'(T_POWERUP - 1)) state_next = INIT;
      INIT: begin
        out_req_next.rs   = 1'b0;
        out_req_next.data = INIT_ROM[idx];
        state_next        = SETUP;
      end
      IDLE: begin
        if (!empty) begin
          pop          = 1'b1;
          out_req_next = head_c;
          state_next   = SETUP;
        end
      end
      SETUP: if (timer == CNT_W'(T_SETUP - 1)) state_next = ENH;
      ENH:   if (timer == CNT_W'(T_EN - 1))    state_next = HOLD;
      HOLD:  if (timer == CNT_W'(T_HOLD - 1))  state_next = EXEC;
      EXEC: begin
        if (timer == exec_last) begin
          if (init_done) begin
            state_next = IDLE;
          end else if (idx == IDX_W'(INIT_LEN - 1)) begin
            init_done_next = 1'b1;
            state_next     = IDLE;
          end else begin
            idx_next   = idx + IDX_W'(1);
            state_next = INIT;
          end
        end
      end
      default: state_next = PWRUP;
    endcase
    if ((state_next != state) || (state == IDLE)) timer_next = '0;
    en_next = (state_next == ENH);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= PWRUP;
      timer     <= '0;
      idx       <= '0;
      init_done <= 1'b0;
      out_req   <= '0;
      lcd_en_o  <= 1'b0;
      lcd_on_o  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_next;
      timer     <= timer_next;
      idx       <= idx_next;
      init_done <= init_done_next;
      out_req   <= out_req_next;
      lcd_en_o  <= en_next;
      lcd_on_o  <= 1'b1;
      if (req_valid_i && !req_ready_o) overflow <= 1'b1;
    end
  end

  assign lcd_data_o = out_req.data;
  assign lcd_rs_o   = out_req.rs;
  assign lcd_rw_o   = 1'b0;

  assign busy_o   = (state != IDLE) || !empty;
  assign status_o = {busy_o, init_done, overflow, 26'd0, 3'(fifo_count)};

endmodule
